// File: rtl/fetching_stage.sv
// Instruction-fetch stage: program counter, boot-vector load from word 0,
// jump redirection with a one-bubble flush, stall hold and HLT detection.
module fetching_stage #(
    parameter logic [15:0] NOP_WORD   = 16'h0000,
    parameter logic [4:0]  HLT_OPCODE = 5'b00001
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        jump_occured,
    input  logic [15:0] jump_target,
    output logic [15:0] instruction,
    output logic [15:0] pc_buf,
    output logic        halted
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OPC_W  = 5;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_buf_q, pc_buf_d;
    logic                halted_q, halted_d;
    logic                fetched_hlt_c;
    logic [ADDR_W-1:0]   pc_inc_c;

    assign fetched_hlt_c = (imem_data[WORD_W-1 -: OPC_W] == HLT_OPCODE);
    assign pc_inc_c      = pc_q + ADDR_W'(1);

    // Next-state and next-register computation; everything holds unless a case updates it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_buf_d = pc_buf_q;

        case (state_q)
            S_BOOT: begin
                // Word 0 holds the start address; stall and jump are ignored here.
                pc_d    = imem_data;
                instr_d = NOP_WORD;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (jump_occured) begin
                    pc_d     = jump_target;
                    instr_d  = NOP_WORD;
                    pc_buf_d = '0;
                end else if (!stall) begin
                    instr_d  = imem_data;
                    pc_buf_d = pc_q;
                    if (fetched_hlt_c) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_inc_c;
                    end
                end
            end
            S_HALT: begin
                // A jump here means the HLT was fetched down a mispredicted path.
                if (jump_occured) begin
                    pc_d     = jump_target;
                    instr_d  = NOP_WORD;
                    pc_buf_d = '0;
                    state_d  = S_RUN;
                end else if (!stall) begin
                    instr_d = NOP_WORD;
                end
            end
            default: begin
                state_d = S_BOOT;
                pc_d    = '0;
                instr_d = NOP_WORD;
            end
        endcase

        halted_d = (state_d == S_HALT);
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_BOOT;
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            pc_buf_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_buf_q <= pc_buf_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_buf      = pc_buf_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetching_stage.sv
// Directed bench for fetching_stage: expected IF/ID contents are queued with each
// stimulus step and compared one edge later against a behavioural instruction memory.
module tb_fetching_stage;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        jump_occured;
    logic [15:0] jump_target;
    logic [15:0] instruction;
    logic [15:0] pc_buf;
    logic        halted;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcb;
        logic [15:0] pc;
        logic        halt;
        bit          chk_pcb;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    fetching_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .jump_occured (jump_occured),
        .jump_target  (jump_target),
        .instruction  (instruction),
        .pc_buf       (pc_buf),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare.
    task automatic step(input string tag, input logic rst, input logic st, input logic jo,
                        input logic [15:0] jt, input logic [15:0] e_instr,
                        input logic [15:0] e_pcb, input logic [15:0] e_pc,
                        input logic e_halt, input bit e_chk_pcb);
        exp_t e;
        reset        = rst;
        stall        = st;
        jump_occured = jo;
        jump_target  = jt;
        e.instr   = e_instr;
        e.pcb     = e_pcb;
        e.pc      = e_pc;
        e.halt    = e_halt;
        e.chk_pcb = e_chk_pcb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".instr"}, instruction, e.instr);
        if (e.chk_pcb) chk({tag, ".pc_buf"}, pc_buf, e.pcb);
        chk({tag, ".pc"}, imem_addr, e.pc);
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, e.halt});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'h8000 | 16'(i[14:0]);
        end
        mem[16'h0000] = 16'h0010;
        mem[16'h0010] = 16'hA123;
        mem[16'h0020] = 16'h0800;
        mem[16'h0030] = 16'h1234;
        mem[16'h0040] = 16'h5A5A;

        reset = 1'b0; stall = 1'b0; jump_occured = 1'b0; jump_target = 16'h0000;

        //    tag        rst  st   jo   target    instr     pc_buf    pc        halt  chk_pcb
        step("rst0",     0,   0,   0,   16'h0000, NOP,      16'h0000, 16'h0000, 0,    1);
        step("rst1",     0,   1,   1,   16'h0077, NOP,      16'h0000, 16'h0000, 0,    1);
        // Boot edge ignores stall and jump.
        step("boot",     1,   1,   1,   16'h0055, NOP,      16'h0000, 16'h0010, 0,    1);
        step("f10",      1,   0,   0,   16'h0000, 16'hA123, 16'h0010, 16'h0011, 0,    1);
        step("f11",      1,   0,   0,   16'h0000, 16'h8011, 16'h0011, 16'h0012, 0,    1);
        step("stall1",   1,   1,   0,   16'h0000, 16'h8011, 16'h0011, 16'h0012, 0,    1);
        step("stall2",   1,   1,   0,   16'h0000, 16'h8011, 16'h0011, 16'h0012, 0,    1);
        step("stall3",   1,   1,   0,   16'h0000, 16'h8011, 16'h0011, 16'h0012, 0,    1);
        step("resume",   1,   0,   0,   16'h0000, 16'h8012, 16'h0012, 16'h0013, 0,    1);
        step("jmpstl",   1,   1,   1,   16'h0040, NOP,      16'h0000, 16'h0040, 0,    1);
        step("f40",      1,   0,   0,   16'h0000, 16'h5A5A, 16'h0040, 16'h0041, 0,    1);
        step("jwrap",    1,   0,   1,   16'hFFFE, NOP,      16'h0000, 16'hFFFE, 0,    1);
        step("wFFFE",    1,   0,   0,   16'h0000, 16'hFFFE, 16'hFFFE, 16'hFFFF, 0,    1);
        step("wFFFF",    1,   0,   0,   16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 0,    1);
        step("w0000",    1,   0,   0,   16'h0000, 16'h0010, 16'h0000, 16'h0001, 0,    1);
        step("w0001",    1,   0,   0,   16'h0000, 16'h8001, 16'h0001, 16'h0002, 0,    1);
        step("j1f",      1,   0,   1,   16'h001F, NOP,      16'h0000, 16'h001F, 0,    1);
        step("f1f",      1,   0,   0,   16'h0000, 16'h801F, 16'h001F, 16'h0020, 0,    1);
        step("hlt",      1,   0,   0,   16'h0000, 16'h0800, 16'h0020, 16'h0020, 1,    1);
        step("hstall",   1,   1,   0,   16'h0000, 16'h0800, 16'h0020, 16'h0020, 1,    1);
        step("hnop1",    1,   0,   0,   16'h0000, NOP,      16'h0020, 16'h0020, 1,    1);
        step("hnop2",    1,   0,   0,   16'h0000, NOP,      16'h0020, 16'h0020, 1,    1);
        step("hjump",    1,   0,   1,   16'h0030, NOP,      16'h0000, 16'h0030, 0,    0);
        step("f30",      1,   0,   0,   16'h0000, 16'h1234, 16'h0030, 16'h0031, 0,    1);
        step("j20",      1,   0,   1,   16'h0020, NOP,      16'h0000, 16'h0020, 0,    1);
        step("hlt2",     1,   0,   0,   16'h0000, 16'h0800, 16'h0020, 16'h0020, 1,    1);
        // Reset during HALT with stall held must still win.
        step("rsthalt",  0,   1,   0,   16'h0000, NOP,      16'h0000, 16'h0000, 0,    1);
        step("reboot",   1,   0,   0,   16'h0000, NOP,      16'h0000, 16'h0010, 0,    1);
        step("rf10",     1,   0,   0,   16'h0000, 16'hA123, 16'h0010, 16'h0011, 0,    1);

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
